// File: rtl/trig_enc_sched_pkg.sv
// Shared DMB constants for the trigger encoder scheduler: CFEB count, timing limits,
// slot FSM encoding and the saturating drop-counter helper.
package trig_enc_sched_pkg;

  localparam int unsigned NUM_CFEB     = 5;
  localparam int unsigned HOLD_LEN_MIN = 1;
  localparam int unsigned HOLD_LEN_MAX = 15;
  localparam int unsigned GAP_LEN_MAX  = 15;
  localparam int unsigned CNT_W        = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StHold  = 2'd1,
    StRsync = 2'd2,
    StGap   = 2'd3
  } slot_state_e;

  // Add a small per-cycle drop count to the 8-bit counter, sticking at 8'hFF.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {5'd0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/trig_pend_cell.sv
// Per-CFEB pending flags (pre-LCT and L1A-match) with drop detection.
// A pulse landing on a flag that is being loaded re-arms it and is not a drop.
module trig_pend_cell
  import trig_enc_sched_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_flush,
  input  logic i_lct,
  input  logic i_match,
  input  logic i_ld_lct,
  input  logic i_ld_match,
  output logic o_pend_lct,
  output logic o_pend_match,
  output logic o_drop_lct,
  output logic o_drop_match
);

  logic r_lct;
  logic r_match;

  // A pulse is dropped only when its flag is set and stays set this cycle.
  always_comb begin
    o_drop_lct   = i_lct & r_lct & ~i_ld_lct & ~i_flush;
    o_drop_match = i_match & r_match & ~i_ld_match & ~i_flush;
  end

  // Pending flags: flush clears and ignores pulses, otherwise set wins over load-clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lct   <= 1'b0;
      r_match <= 1'b0;
    end else if (i_flush) begin
      r_lct   <= 1'b0;
      r_match <= 1'b0;
    end else begin
      r_lct   <= (r_lct & ~i_ld_lct) | i_lct;
      r_match <= (r_match & ~i_ld_match) | i_match;
    end
  end

  assign o_pend_lct   = r_lct;
  assign o_pend_match = r_match;

endmodule

// File: rtl/trig_enc_sched.sv
// Trigger encoder scheduler: collects per-CFEB pre-LCT / L1A-match pulses and the L1A
// broadcast into pending flags and serves them as fixed-length, gap-separated slots.
// Bypass mode passes inputs straight through with one cycle of latency.
module trig_enc_sched
  import trig_enc_sched_pkg::*;
#(
  parameter int unsigned HOLD_LEN = 2,
  parameter int unsigned GAP_LEN  = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENCODE,
  input  logic       DCFEB_IN_USE,
  input  logic       RESYNC_RST,
  input  logic       L1ACFEB,
  input  logic [5:1] PRE_LCT_IN,
  input  logic [5:1] L1A_MATCH_IN,
  output logic [5:1] PRE_LCT_OUT,
  output logic [5:1] L1A_MATCH,
  output logic       L1ACFEB_OUT,
  output logic       RESYNC_OUT,
  output logic       SLOT_BUSY,
  output logic [7:0] DROP_CNT
);

  // Counter reload values; a count of 0 means "last cycle of this phase".
  localparam logic [CNT_W-1:0] HoldLd = CNT_W'(HOLD_LEN - 1);
  localparam logic [CNT_W-1:0] GapLd  = (GAP_LEN == 0) ? '0 : CNT_W'(GAP_LEN - 1);

  slot_state_e      r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [5:1]       r_lct_out, w_lct_d;
  logic [5:1]       r_match_out, w_match_d;
  logic             r_l1a_out, w_l1a_d;
  logic             r_rs_out, w_rs_d;
  logic             r_busy;
  logic [7:0]       r_drop;
  logic             r_pend_l1a;

  logic [5:1]       w_pend_lct, w_pend_match;
  logic [5:1]       w_drop_lct, w_drop_match;
  logic [5:1]       w_ld_match_bits;
  logic             w_bypass, w_flush, w_any, w_load, w_drop_l1a;
  logic [3:0]       w_drop_sum;

  // Slot control: a match alone cannot open a slot, it waits for an L1A.
  always_comb begin
    w_bypass        = ~ENCODE | DCFEB_IN_USE;
    w_flush         = w_bypass | RESYNC_RST | (r_state == StRsync);
    w_any           = (|w_pend_lct) | r_pend_l1a;
    w_load          = ~w_flush & (r_state == StIdle) & w_any;
    w_ld_match_bits = w_pend_match & {5{r_pend_l1a}};
    w_drop_l1a      = L1ACFEB & r_pend_l1a & ~w_load & ~w_flush;
  end

  for (genvar g = 1; g <= NUM_CFEB; g++) begin : g_cell
    trig_pend_cell u_cell (
      .i_clk       (CLK),
      .i_rst       (RST),
      .i_flush     (w_flush),
      .i_lct       (PRE_LCT_IN[g]),
      .i_match     (L1A_MATCH_IN[g]),
      .i_ld_lct    (w_load),
      .i_ld_match  (w_load & r_pend_l1a),
      .o_pend_lct  (w_pend_lct[g]),
      .o_pend_match(w_pend_match[g]),
      .o_drop_lct  (w_drop_lct[g]),
      .o_drop_match(w_drop_match[g])
    );
  end

  // Total dropped bits this cycle (at most 11).
  always_comb begin
    w_drop_sum = {3'd0, w_drop_l1a};
    for (int i = 1; i <= NUM_CFEB; i++) begin
      w_drop_sum = w_drop_sum + {3'd0, w_drop_lct[i]} + {3'd0, w_drop_match[i]};
    end
  end

  // Next-state and next-output logic for the slot FSM.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_lct_d   = r_lct_out;
    w_match_d = r_match_out;
    w_l1a_d   = r_l1a_out;
    w_rs_d    = r_rs_out;
    if (w_bypass) begin
      w_state_d = StIdle;
      w_cnt_d   = '0;
      w_lct_d   = PRE_LCT_IN;
      w_match_d = L1A_MATCH_IN;
      w_l1a_d   = L1ACFEB;
      w_rs_d    = RESYNC_RST;
    end else if (RESYNC_RST) begin
      w_state_d = StRsync;
      w_cnt_d   = HoldLd;
      w_lct_d   = '0;
      w_match_d = '0;
      w_l1a_d   = 1'b0;
      w_rs_d    = 1'b1;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_lct_d   = '0;
          w_match_d = '0;
          w_l1a_d   = 1'b0;
          w_rs_d    = 1'b0;
          if (w_any) begin
            w_state_d = StHold;
            w_cnt_d   = HoldLd;
            w_lct_d   = w_pend_lct;
            w_match_d = w_ld_match_bits;
            w_l1a_d   = r_pend_l1a;
          end
        end
        StHold, StRsync: begin
          if (r_cnt == '0) begin
            w_lct_d   = '0;
            w_match_d = '0;
            w_l1a_d   = 1'b0;
            w_rs_d    = 1'b0;
            w_state_d = (GAP_LEN == 0) ? StIdle : StGap;
            w_cnt_d   = GapLd;
          end else begin
            w_cnt_d = r_cnt - 1'b1;
          end
        end
        StGap: begin
          w_lct_d   = '0;
          w_match_d = '0;
          w_l1a_d   = 1'b0;
          w_rs_d    = 1'b0;
          if (r_cnt == '0) begin
            w_state_d = StIdle;
          end else begin
            w_cnt_d = r_cnt - 1'b1;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // State, counter, output, L1A-pending and drop-counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_lct_out   <= '0;
      r_match_out <= '0;
      r_l1a_out   <= 1'b0;
      r_rs_out    <= 1'b0;
      r_busy      <= 1'b0;
      r_drop      <= 8'h00;
      r_pend_l1a  <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_lct_out   <= w_lct_d;
      r_match_out <= w_match_d;
      r_l1a_out   <= w_l1a_d;
      r_rs_out    <= w_rs_d;
      r_busy      <= (w_state_d != StIdle);
      r_drop      <= sat_add8(r_drop, w_drop_sum);
      r_pend_l1a  <= w_flush ? 1'b0 : ((r_pend_l1a & ~w_load) | L1ACFEB);
    end
  end

  assign PRE_LCT_OUT = r_lct_out;
  assign L1A_MATCH   = r_match_out;
  assign L1ACFEB_OUT = r_l1a_out;
  assign RESYNC_OUT  = r_rs_out;
  assign SLOT_BUSY   = r_busy;
  assign DROP_CNT    = r_drop;

endmodule

// File: tb/tb_trig_enc_sched.sv
// Directed bench for trig_enc_sched with default HOLD_LEN=2, GAP_LEN=1.
// Inputs change 1ns after a rising edge; outputs are read there too.
module tb_trig_enc_sched;

  logic       clk = 1'b0;
  logic       rst, encode, dcfeb, resync, l1a;
  logic [5:1] lct_in, match_in;
  logic [5:1] lct_out, match_out;
  logic       l1a_out, rs_out, busy;
  logic [7:0] drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trig_enc_sched dut (
    .CLK         (clk),
    .RST         (rst),
    .ENCODE      (encode),
    .DCFEB_IN_USE(dcfeb),
    .RESYNC_RST  (resync),
    .L1ACFEB     (l1a),
    .PRE_LCT_IN  (lct_in),
    .L1A_MATCH_IN(match_in),
    .PRE_LCT_OUT (lct_out),
    .L1A_MATCH   (match_out),
    .L1ACFEB_OUT (l1a_out),
    .RESYNC_OUT  (rs_out),
    .SLOT_BUSY   (busy),
    .DROP_CNT    (drop)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All six outputs packed: {lct, match, l1a, rs, busy} plus drop checked separately.
  function automatic logic [12:0] outs();
    return {lct_out, match_out, l1a_out, rs_out, busy};
  endfunction

  task automatic check_outs(input string tag, input logic [5:1] e_lct, input logic [5:1] e_match,
                            input logic e_l1a, input logic e_rs, input logic e_busy);
    logic [12:0] o;
    logic [12:0] e;
    o = outs();
    e = {e_lct, e_match, e_l1a, e_rs, e_busy};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed lct=%b match=%b l1a=%b rs=%b busy=%b expected lct=%b match=%b l1a=%b rs=%b busy=%b",
             tag, o[12:8], o[7:3], o[2], o[1], o[0], e[12:8], e[7:3], e[2], e[1], e[0]);
    end
  endtask

  initial begin
    rst = 1'b1; encode = 1'b1; dcfeb = 1'b0; resync = 1'b0; l1a = 1'b0;
    lct_in = '0; match_in = '0;
    step(); step();
    check_outs("reset_outs", 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
    check("reset_drop", drop, 8'h00);
    rst = 1'b0;
    step();

    // Single pre-LCT pulse: 2-cycle latency, held 2 cycles, 1 gap cycle.
    lct_in = 5'b00100; step(); lct_in = '0;
    check_outs("lct_t0", 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
    step(); check_outs("lct_t1", 5'b00100, 5'b0, 1'b0, 1'b0, 1'b1);
    step(); check_outs("lct_t2", 5'b00100, 5'b0, 1'b0, 1'b0, 1'b1);
    step(); check_outs("lct_gap", 5'b0, 5'b0, 1'b0, 1'b0, 1'b1);
    step(); check_outs("lct_idle", 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);

    // L1A with match in the same slot.
    l1a = 1'b1; match_in = 5'b00010; step(); l1a = 1'b0; match_in = '0;
    step(); check_outs("l1a_match_a", 5'b0, 5'b00010, 1'b1, 1'b0, 1'b1);
    step(); check_outs("l1a_match_b", 5'b0, 5'b00010, 1'b1, 1'b0, 1'b1);
    step(); check_outs("l1a_match_gap", 5'b0, 5'b0, 1'b0, 1'b0, 1'b1);
    step();

    // Match alone waits for the next L1A.
    match_in = 5'b01000; step(); match_in = '0;
    step(); check_outs("match_alone_a", 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
    step(); check_outs("match_alone_b", 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
    l1a = 1'b1; step(); l1a = 1'b0;
    step(); check_outs("match_late_l1a", 5'b0, 5'b01000, 1'b1, 1'b0, 1'b1);
    step(); step(); step();
    check_outs("match_late_done", 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);

    // Three back-to-back pulses on CFEB 1: served, re-armed, dropped.
    lct_in = 5'b00001; step(); step();
    check_outs("rearm_slot1", 5'b00001, 5'b0, 1'b0, 1'b0, 1'b1);
    step(); lct_in = '0;
    check("drop_one", drop, 8'h01);
    step(); check_outs("rearm_gap", 5'b0, 5'b0, 1'b0, 1'b0, 1'b1);
    step(); check_outs("rearm_idle", 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
    step(); check_outs("rearm_slot2", 5'b00001, 5'b0, 1'b0, 1'b0, 1'b1);
    step(); step(); step();
    check("drop_still_one", drop, 8'h01);

    // Resync mid-hold with everything pending.
    lct_in = 5'b11111; step(); step(); lct_in = '0;
    check_outs("rs_pre_hold", 5'b11111, 5'b0, 1'b0, 1'b0, 1'b1);
    resync = 1'b1; step(); resync = 1'b0;
    check_outs("rs_a", 5'b0, 5'b0, 1'b0, 1'b1, 1'b1);
    step(); check_outs("rs_b", 5'b0, 5'b0, 1'b0, 1'b1, 1'b1);
    step(); check_outs("rs_gap", 5'b0, 5'b0, 1'b0, 1'b0, 1'b1);
    step(); step();
    check_outs("rs_no_later_slot", 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
    check("rs_drop_kept", drop, 8'h01);

    // Repeated resync restarts the count; pulses during RSYNC are ignored.
    resync = 1'b1; step(); resync = 1'b0;
    lct_in = 5'b00010; step(); lct_in = '0;
    resync = 1'b1; step(); resync = 1'b0;
    check_outs("rs_restart", 5'b0, 5'b0, 1'b0, 1'b1, 1'b1);
    step(); check_outs("rs_restart_b", 5'b0, 5'b0, 1'b0, 1'b1, 1'b1);
    step(); step(); step();
    check_outs("rs_ignored_pulse", 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);

    // Bypass via DCFEB_IN_USE.
    encode = 1'b0; dcfeb = 1'b1; match_in = 5'b10000; step(); match_in = '0;
    check_outs("byp_match", 5'b0, 5'b10000, 1'b0, 1'b0, 1'b0);
    step(); check_outs("byp_match_clr", 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
    encode = 1'b1; lct_in = 5'b01000; step(); lct_in = '0;
    check_outs("byp_dcfeb_only", 5'b01000, 5'b0, 1'b0, 1'b0, 1'b0);
    dcfeb = 1'b0; encode = 1'b0; resync = 1'b1; step(); resync = 1'b0;
    check_outs("byp_resync", 5'b0, 5'b0, 1'b0, 1'b1, 1'b0);
    encode = 1'b1; step(); step();
    check_outs("byp_exit_idle", 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);

    // Bypass mid-slot aborts and clears pending.
    lct_in = 5'b00001; step(); lct_in = '0; step();
    check_outs("abort_pre", 5'b00001, 5'b0, 1'b0, 1'b0, 1'b1);
    encode = 1'b0; step();
    check_outs("abort_now", 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
    encode = 1'b1; step(); step();
    check_outs("abort_no_slot", 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);

    // Continuous pulse on CFEB 1: 3 drops per 4-cycle slot after the first load.
    lct_in = 5'b00001;
    for (int i = 0; i < 9; i++) step();
    check("drop_count_7", drop, 8'h07);
    for (int i = 0; i < 500; i++) step();
    lct_in = '0;
    check("drop_saturated", drop, 8'hFF);
    step();
    check("drop_stays_ff", drop, 8'hFF);

    // Reset clears everything; a pulse in the reset cycle is lost.
    rst = 1'b1; lct_in = 5'b11111; step(); rst = 1'b0; lct_in = '0;
    check("rst_drop", drop, 8'h00);
    check_outs("rst_outs", 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
    step(); step();
    check_outs("rst_pulse_lost", 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
